// File: rtl/tt_um_test123.sv
// tt_um_test123 -- Tiny Tapeout user block that streams "Hello, World!\n".
//
// Outputs one character of the message at a time. The character index
// advances on a prescaler tick while run is set, or on a single-step rising
// edge while run is clear.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous reset, ACTIVE-HIGH (the name is the harness's)
//   ena      in   design selected; 0 freezes idx/pc/wrap
//   ui_in    in   [0] run, [1] step, [2] restart, [6:3] rate R, [7] display mode
//   uo_out   out  current character (ASCII, or 7-segment when enabled)
//   uio_in   in   unused
//   uio_out  out  [3:0] index, [4] wrap strobe, [7:5] zero
//   uio_oe   out  constant 8'h1F
//
// Build option: define SEVENSEG_EN to add the 7-segment display mode,
// which is selected at run time by ui_in[7].
module tt_um_test123 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [3:0]  r_idx;
  logic [14:0] r_pc;
  logic        r_step_d;
  logic        r_wrap;

  logic        w_run;
  logic        w_step_pulse;
  logic        w_restart;
  logic [3:0]  w_rate;
  logic [14:0] w_mask;
  logic        w_tick;
  logic        w_advance;
  logic [7:0]  w_ascii;

  assign w_run     = ui_in[0];
  assign w_restart = ui_in[2];
  assign w_rate    = ui_in[6:3];

  // Low R bits set; R = 15 shifts everything out and yields 15'h7FFF.
  assign w_mask       = ~(15'h7FFF << w_rate);
  assign w_tick       = w_run && ((r_pc & w_mask) == w_mask);
  assign w_step_pulse = ui_in[1] && !r_step_d;
  assign w_advance    = w_tick || (w_step_pulse && !w_run);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_idx    <= '0;
      r_pc     <= '0;
      r_wrap   <= 1'b0;
      r_step_d <= 1'b0;
    end else begin
      // Edge detector keeps tracking while deselected.
      r_step_d <= ui_in[1];
      if (ena) begin
        if (w_restart) begin
          r_idx  <= '0;
          r_pc   <= '0;
          r_wrap <= 1'b0;
        end else begin
          if (w_run) r_pc <= r_pc + 15'd1;
          r_wrap <= w_advance && (r_idx == 4'd13);
          if (w_advance) r_idx <= (r_idx == 4'd13) ? 4'd0 : r_idx + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_ascii = 8'h00;
    case (r_idx)
      4'd0:  w_ascii = 8'h48;
      4'd1:  w_ascii = 8'h65;
      4'd2:  w_ascii = 8'h6C;
      4'd3:  w_ascii = 8'h6C;
      4'd4:  w_ascii = 8'h6F;
      4'd5:  w_ascii = 8'h2C;
      4'd6:  w_ascii = 8'h20;
      4'd7:  w_ascii = 8'h57;
      4'd8:  w_ascii = 8'h6F;
      4'd9:  w_ascii = 8'h72;
      4'd10: w_ascii = 8'h6C;
      4'd11: w_ascii = 8'h64;
      4'd12: w_ascii = 8'h21;
      4'd13: w_ascii = 8'h0A;
      default: w_ascii = 8'h00;
    endcase
  end

`ifdef SEVENSEG_EN
  logic [6:0] w_seg;

  // Segment order gfedcba, active-high.
  always_comb begin
    w_seg = 7'h00;
    case (w_ascii)
      8'h48: w_seg = 7'h76;  // H
      8'h65: w_seg = 7'h7B;  // e
      8'h6C: w_seg = 7'h30;  // l
      8'h6F: w_seg = 7'h5C;  // o
      8'h2C: w_seg = 7'h04;  // ,
      8'h57: w_seg = 7'h3E;  // W
      8'h72: w_seg = 7'h50;  // r
      8'h64: w_seg = 7'h5E;  // d
      8'h21: w_seg = 7'h02;  // !
      default: w_seg = 7'h00; // space, newline
    endcase
  end

  assign uo_out = ui_in[7] ? {1'b0, w_seg} : w_ascii;

  logic w_unused;
  assign w_unused = &{1'b0, uio_in};
`else
  assign uo_out = w_ascii;

  logic w_unused;
  assign w_unused = &{1'b0, uio_in, ui_in[7]};
`endif

  assign uio_out = {3'b000, r_wrap, r_idx};
  assign uio_oe  = 8'h1F;

endmodule

// File: tb/tb_tt_um_test123.sv
// Directed testbench for tt_um_test123: reset state, free-running at two
// rates with the wrap strobe, single-step edge detection, restart and ena
// gating, and the display-mode decode (expectations follow SEVENSEG_EN).
module tb_tt_um_test123;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int unsigned n_vec;
  int unsigned n_err;

  logic [7:0] rom [0:13];

  tt_um_test123 dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned k;
    logic [3:0]  e_idx;
    logic        e_wrap;

    rom[0]  = 8'h48; rom[1]  = 8'h65; rom[2]  = 8'h6C; rom[3]  = 8'h6C;
    rom[4]  = 8'h6F; rom[5]  = 8'h2C; rom[6]  = 8'h20; rom[7]  = 8'h57;
    rom[8]  = 8'h6F; rom[9]  = 8'h72; rom[10] = 8'h6C; rom[11] = 8'h64;
    rom[12] = 8'h21; rom[13] = 8'h0A;

    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'hA5;

    // Reset held two cycles, then idle for 20.
    cyc();
    cyc();
    check("rst_uo", uo_out, 8'h48);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'h1F);
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("idle_uo", uo_out, 8'h48);
      check("idle_uio", uio_out, 8'h00);
      check("idle_oe", uio_oe, 8'h1F);
    end

    // run, R = 0: one character per cycle, wrap after 13 -> 0.
    ui_in = 8'h01;
    for (k = 1; k <= 16; k++) begin
      cyc();
      e_idx  = 4'(k % 14);
      e_wrap = (k == 14);
      check("r0_uo", uo_out, rom[e_idx]);
      check("r0_uio", uio_out, {3'b000, e_wrap, e_idx});
    end

    // Restart clears idx and pc.
    ui_in = 8'h04;
    cyc();
    check("restart0", uio_out, 8'h00);

    // run, R = 3: first advance on the 8th running cycle, then every 8.
    ui_in = 8'h19;
    for (k = 1; k <= 24; k++) begin
      cyc();
      e_idx = 4'(k / 8);
      check("r3_idx", uio_out, {4'h0, e_idx});
    end

    // Single step: 0,1,1,0,1 then hold high -> two advances only.
    ui_in = 8'h04;
    cyc();
    check("restart1", uio_out, 8'h00);
    ui_in = 8'h00; cyc(); check("step_a", uio_out, 8'h00);
    ui_in = 8'h02; cyc(); check("step_b", uio_out, 8'h01);
    ui_in = 8'h02; cyc(); check("step_c", uio_out, 8'h01);
    ui_in = 8'h00; cyc(); check("step_d", uio_out, 8'h01);
    ui_in = 8'h02; cyc(); check("step_e", uio_out, 8'h02);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("step_hold", uio_out, 8'h02);
    end
    check("step_uo", uo_out, 8'h6C);

    // Step is ignored while running; R = 15 gives no tick here.
    ui_in = 8'h79;
    cyc();
    check("step_run_ign", uio_out, 8'h02);
    ui_in = 8'h7B;
    cyc();
    check("step_run_ign2", uio_out, 8'h02);

    // Run R = 2 from a restart up to idx 9 (36 cycles).
    ui_in = 8'h04;
    cyc();
    ui_in = 8'h11;
    for (int i = 0; i < 36; i++) cyc();
    check("r2_idx9", uio_out, 8'h09);
    check("r2_uo9", uo_out, 8'h72);

    // Restart mid-run: idx 0, no wrap, pc restarts so next tick is 4 cycles on.
    ui_in = 8'h15;
    cyc();
    check("rs_mid", uio_out, 8'h00);
    ui_in = 8'h11;
    for (k = 1; k <= 4; k++) begin
      cyc();
      check("rs_resume", uio_out, (k == 4) ? 8'h01 : 8'h00);
    end

    // ena = 0: restart and run are both ignored, pc frozen.
    ena   = 1'b0;
    ui_in = 8'h15;
    cyc();
    check("ena0_rs", uio_out, 8'h01);
    ui_in = 8'h11;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("ena0_run", uio_out, 8'h01);
    end
    ena = 1'b1;
    for (k = 1; k <= 4; k++) begin
      cyc();
      check("ena1_run", uio_out, (k == 4) ? 8'h02 : 8'h01);
    end

    // Display mode at idx 0 and idx 4.
    ui_in = 8'h84;
    cyc();
    check("disp_idx0_i", uio_out, 8'h00);
`ifdef SEVENSEG_EN
    check("disp_idx0", uo_out, 8'h76);
`else
    check("disp_idx0", uo_out, 8'h48);
`endif
    for (int i = 0; i < 4; i++) begin
      ui_in = 8'h82; cyc();
      ui_in = 8'h80; cyc();
    end
    check("disp_idx4_i", uio_out, 8'h04);
`ifdef SEVENSEG_EN
    check("disp_idx4", uo_out, 8'h5C);
`else
    check("disp_idx4", uo_out, 8'h6F);
`endif
    ui_in = 8'h00;
    #1;
    check("disp_ascii4", uo_out, 8'h6F);

    // Reset mid-stream.
    rst_n = 1'b1;
    cyc();
    check("rst_mid", uio_out, 8'h00);
    rst_n = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_test123.md
# tt_um_test123

Top-level Tiny Tapeout user block that streams the fixed message "Hello, World!\n" one character at a time. The character index advances at a programmable rate set by `ui_in`, or by manual single-step. The current character is driven on `uo_out`, and the index plus a wrap strobe are driven on the bidirectional pins. The block sits directly under the chip harness and has no submodules beyond its own message ROM and prescaler.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; one clock, synchronous and active-high (reset asserted when `rst_n` = 1; port name kept for harness compatibility).
- `ena`  in  1  design selected; when 0, all state holds (no advance, prescaler frozen).
- `ui_in`  in  8  [0] run, [1] step, [2] restart, [6:3] rate R, [7] display mode.
- `uo_out`  out  8  current character (ASCII, or 7-segment when enabled).
- `uio_in`  in  8  unused, ignored.
- `uio_out`  out  8  [3:0] index, [4] wrap strobe, [7:5] = 0.
- `uio_oe`  out  8  constant 8'h1F.

## Operation
- Message ROM, 14 entries, index 0..13: 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 21 0A (hex).
- State registers:
  - `idx` (4 b)
  - prescaler `pc` (15 b)
  - `step_d` (previous `ui_in[1]`)
  - `wrap` (1 b)
- Prescaler:
  - mask = (1<<R) − 1.
  - When run = 1, `pc` increments each cycle and wraps modulo 2^15.
  - When run = 0, `pc` holds.
  - tick = run & ((pc & mask) == mask). With R = 0, tick occurs every cycle.
- Step: `step_pulse` = `ui_in[1]` & ~`step_d`. It is honoured only when run = 0 and ignored when run = 1.
- Advance = tick | (step_pulse & ~run). On advance, `idx` ← (`idx` == 13) ? 0 : `idx`+1.
- Restart (`ui_in[2]` = 1): `idx` ← 0 and `pc` ← 0 on that edge. Restart overrides advance; reset overrides everything.
- Wrap strobe: `wrap` ← 1 on the edge where advance takes `idx` from 13 to 0, otherwise 0. Restart never sets it.
- `uo_out` is a combinational decode of the `idx` register: ROM[`idx`], or the segment code per Configuration.
- `uio_out[3:0]` = `idx`; `uio_out[4]` = `wrap`.
- Inputs are sampled directly, with no synchronizers; the harness guarantees synchronous inputs.
- `ena` = 0: `idx`, `pc` and `wrap` hold, and `step_d` still tracks `ui_in[1]`.

## Timing
- Reset values:
  - `idx` = 0, `pc` = 0, `wrap` = 0, `step_d` = 0.
  - Hence `uo_out` = 8'h48 (ASCII) and `uio_out` = 8'h00.
  - `uio_oe` = 8'h1F at all times.
- Advance latency: the new character appears on `uo_out` immediately after the clock edge at which tick or step_pulse is high (one edge, no extra pipeline).
- Steady run at rate R: one advance every 2^R cycles. The first tick after reset or restart occurs when `pc` = mask, i.e. on the (2^R)-th running cycle.
- Changing R mid-count takes effect on the next comparison; no reset of `pc` occurs.
- `wrap` is high for exactly one cycle following the 13→0 advance. With R = 0 it pulses every 14 cycles.
- Reset or restart mid-stream: `idx` returns to 0 on that edge, and a pending step edge in the same cycle is discarded.

## Configuration
- Macro `SEVENSEG_EN`.
- Defined: when `ui_in[7]` = 1, `uo_out[6:0]` drives the segment pattern (gfedcba, active-high) and `uo_out[7]` = 0. Codes:
  - H = 76, e = 7B, l = 30, o = 5C
  - , = 04, space = 00, W = 3E, r = 50
  - d = 5E, ! = 02, \n = 00 (hex)
  - When `ui_in[7]` = 0, `uo_out` carries ASCII.
- Undefined: `ui_in[7]` is ignored and `uo_out` is always ASCII. No segment logic is synthesized.

## Test plan
- Reset held 2 cycles, then released with `ui_in` = 0 → `uo_out` = 0x48, `uio_out` = 0x00, `uio_oe` = 0x1F, all stable for 20 cycles.
- run = 1, R = 0 → `uo_out` sequence 48 65 6C 6C 6F 2C 20 57 6F 72 6C 64 21 0A 48..., one per cycle. `uio_out[4]` = 1 exactly in the cycle `idx` first reads 0 after 0x0A.
- run = 1, R = 3 → `idx` increments every 8 cycles, with the first increment 8 cycles after release.
- run = 0, toggle `ui_in[1]` 0→1→1→0→1 → exactly two advances (`idx` 0→2). Holding step high gives no further advance.
- During a run at idx = 9, assert restart one cycle → `idx` = 0, `wrap` stays 0, and counting resumes from `pc` = 0. Same check with `ena` = 0 → no change.
- With `SEVENSEG_EN`, `ui_in[7]` = 1 at idx 0 and idx 4 → `uo_out` = 0x76 and 0x5C. Without the macro → 0x48 and 0x6F.
